// File: rtl/vscale_dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes and phase-tracking states.
package vscale_dmem_responder_pkg;

    localparam logic [1:0] DMEM_SIZE_B = 2'd0;
    localparam logic [1:0] DMEM_SIZE_H = 2'd1;
    localparam logic [1:0] DMEM_SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_STALL = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/vscale_dmem_lane_mask.sv
// Decodes access size and low address bits into a byte-lane write mask and a misalignment flag.
module vscale_dmem_lane_mask
    import vscale_dmem_responder_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] mask,
    output logic       misaligned
);

    always_comb begin
        mask       = 4'b0000;
        misaligned = 1'b0;
        case (size)
            DMEM_SIZE_B: mask = 4'b0001 << addr_lo;
            DMEM_SIZE_H: begin
                mask       = 4'b0011 << {addr_lo[1], 1'b0};
                misaligned = addr_lo[0];
            end
            DMEM_SIZE_W: begin
                mask       = 4'b1111;
                misaligned = |addr_lo;
            end
            default: misaligned = 1'b1;  // size 3 has no defined width
        endcase
    end

endmodule

// File: rtl/vscale_dmem_responder.sv
// Word-addressed SRAM model behind the core's two-phase data port, with optional wait states.
module vscale_dmem_responder
    import vscale_dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_en,
    input  logic        dmem_wen,
    input  logic [2:0]  dmem_size,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata_delayed,
    output logic [31:0] dmem_rdata,
    output logic        dmem_wait,
    output logic        dmem_badmem_e
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    logic [31:0] mem [0:DEPTH_WORDS-1];

    dmem_state_e   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wen_q, wen_d;
    logic          bad_q, bad_d;
    logic [3:0]    mask_q, mask_d;
    logic [AW-1:0] idx_q, idx_d;

    logic [32:0] diff;
    logic        in_range;
    logic [3:0]  req_mask;
    logic        req_misaligned;
    logic        complete;
    logic        accept;
    logic        unused_bits;

    // 33-bit difference keeps addresses below BASE_ADDR and spans that overflow 32 bits out of range.
    assign diff     = {1'b0, dmem_addr} - {1'b0, BASE_ADDR};
    assign in_range = (diff < SPAN);

    vscale_dmem_lane_mask u_lane_mask (
        .size       (dmem_size[1:0]),
        .addr_lo    (dmem_addr[1:0]),
        .mask       (req_mask),
        .misaligned (req_misaligned)
    );

    assign complete    = (state_q == ST_DATA);
    assign dmem_wait   = (state_q == ST_STALL);
    assign accept      = dmem_en && !dmem_wait;
    assign unused_bits = ^{dmem_size[2], diff[32], diff[31:AW+2], diff[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        bad_d   = bad_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        case (state_q)
            ST_STALL: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DATA;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DATA: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // A completing DATA cycle may accept the next address phase in the same cycle.
        if (accept) begin
            state_d = (WAIT_CYCLES == 0) ? ST_DATA : ST_STALL;
            cnt_d   = WAIT_INIT;
            wen_d   = dmem_wen;
            bad_d   = !in_range || req_misaligned;
            mask_d  = req_mask;
            idx_d   = diff[AW+1:2];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wen_q   <= 1'b0;
            bad_q   <= 1'b0;
            mask_q  <= 4'b0000;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            bad_q   <= bad_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && complete && wen_q && !bad_q) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_q[i]) begin
                    mem[idx_q][8*i +: 8] <= dmem_wdata_delayed[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        dmem_rdata    = 32'h0;
        dmem_badmem_e = complete && bad_q;
        if (complete && !bad_q && !wen_q) begin
            dmem_rdata = mem[idx_q];
        end
    end

endmodule
